// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction fetch stage. Owns the architectural fetch PC, issues
//   single-cycle handshake requests to instruction memory and drives the
//   IF/ID pipeline register.
//
//   * BOOT : one dead cycle after reset release, no request.
//   * FETCH: request while the PC is word aligned. A misaligned PC produces
//            a NOP tagged with an address-error flag through the same path
//            as a real memory return.
//   * HOLD : a word returned during a decode stall is parked in a one-entry
//            hold buffer until the stall clears. No request is made here.
//
//   A flush (exception return / syscall redirect) overrides everything else.
//   It squashes IF/ID, drops any held word and loads nextpc.
//   The PC advances only when IF/ID is loaded or on a flush. The +4 and
//   branch arithmetic live in the next-PC logic, which reads pc and if_id_pc
//   back from this block.
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    // next-PC logic interface
    input  logic [31:0] nextpc,
    input  logic        stall,
    input  logic        flush,

    // instruction memory interface
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,

    // fetch PC and IF/ID pipeline register
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        if_id_adel
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        adel;
    } if_id_t;

    // Bubble keeps the PC of the last real instruction. The next-PC logic
    // uses if_id_pc as the delay-slot base, so it must not be disturbed by
    // a squashed or missing fetch.
    function automatic if_id_t make_bubble(input logic [31:0] keep_pc);
        if_id_t b;
        b.pc    = keep_pc;
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        b.adel  = 1'b0;
        return b;
    endfunction

    function automatic if_id_t make_entry(input logic [31:0] entry_pc,
                                          input logic [31:0] entry_instr,
                                          input logic        entry_adel);
        if_id_t e;
        e.pc    = entry_pc;
        e.instr = entry_instr;
        e.valid = 1'b1;
        e.adel  = entry_adel;
        return e;
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        hold_adel_q, hold_adel_d;

    // Fetch return path. An aligned PC returns imem_rdata once memory
    // signals ready. A misaligned PC never reaches memory and returns a
    // NOP carrying the address-error flag in the same cycle.
    logic        fetch_aligned;
    logic        ret_valid;
    logic [31:0] ret_instr;
    logic        ret_adel;

    assign fetch_aligned = (pc_q[1:0] == 2'b00);
    assign ret_valid     = !fetch_aligned || imem_ready;
    assign ret_instr     = fetch_aligned ? imem_rdata : NOP_INSTR;
    assign ret_adel      = !fetch_aligned;

    // No outstanding requests. The address is the PC register, so it stays
    // stable for as long as a request waits for ready.
    assign imem_req  = (state_q == ST_FETCH) && fetch_aligned;
    assign imem_addr = pc_q;

    // Next-state, next-PC, IF/ID and hold-buffer update
    always_comb begin
        // NOTE: every signal assigned in this block gets its default first.
        // Any path that leaves one unassigned would otherwise infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        if_id_d      = if_id_q;
        hold_instr_d = hold_instr_q;
        hold_adel_d  = hold_adel_q;

        if (flush) begin
            // The redirect wins over stall and over any word memory returns
            // this cycle.
            if_id_d      = make_bubble(if_id_q.pc);
            hold_instr_d = NOP_INSTR;
            hold_adel_d  = 1'b0;
            pc_d         = nextpc;
            state_d      = ST_FETCH;
        end else begin
            unique case (state_q)
                ST_BOOT: begin
                    state_d = ST_FETCH;
                end

                ST_FETCH: begin
                    if (ret_valid) begin
                        if (stall) begin
                            // Decode cannot accept the word, so park it
                            hold_instr_d = ret_instr;
                            hold_adel_d  = ret_adel;
                            state_d      = ST_HOLD;
                        end else begin
                            if_id_d = make_entry(pc_q, ret_instr, ret_adel);
                            pc_d    = nextpc;
                        end
                    end else if (!stall) begin
                        // Memory not ready: insert a bubble and retry the same PC
                        if_id_d = make_bubble(if_id_q.pc);
                    end
                end

                ST_HOLD: begin
                    if (!stall) begin
                        if_id_d      = make_entry(pc_q, hold_instr_q, hold_adel_q);
                        pc_d         = nextpc;
                        hold_instr_d = NOP_INSTR;
                        hold_adel_d  = 1'b0;
                        state_d      = ST_FETCH;
                    end
                end

                default: begin
                    state_d = ST_BOOT;
                end
            endcase
        end
    end

    // State, PC, IF/ID and hold-buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from the values of the previous
        // cycle, whatever order the statements are written in.
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            if_id_q      <= make_bubble(RESET_PC);
            // NOTE: the hold buffer is reset explicitly. It is a single
            // entry, and a known value keeps a parked word from a previous
            // run out of simulation and equivalence checks.
            hold_instr_q <= NOP_INSTR;
            hold_adel_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_id_q      <= if_id_d;
            hold_instr_q <= hold_instr_d;
            hold_adel_q  <= hold_adel_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;
    assign if_id_adel  = if_id_q.adel;

    // Interface properties: requests are only ever word aligned, and a
    // waiting request keeps its address.
    a_req_aligned : assert property (@(posedge clk) disable iff (!rst_n)
        imem_req |-> (imem_addr[1:0] == 2'b00));

    a_addr_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req && !imem_ready && !flush) |=> $stable(imem_addr));

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Self-checking bench for if_fetch_stage. A behavioural model tracks the
//   fetch PC, the IF/ID contents, a queue of parked words and a boot flag.
//   On every falling edge one compare process checks all DUT outputs against
//   that model. A directed sequence with literal expectations pins the model.
//   Randomised traffic follows, with occasional asynchronous resets.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] nextpc;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        if_id_adel;

    int n_total = 0;
    int n_bad   = 0;
    bit cmp_en  = 1'b0;

    if_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .nextpc      (nextpc),
        .stall       (stall),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .if_id_adel  (if_id_adel)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] instr;
        logic        adel;
    } held_t;

    logic [31:0] m_pc       = RESET_PC;
    logic [31:0] m_ifid_pc  = RESET_PC;
    logic [31:0] m_instr    = NOP_INSTR;
    logic        m_valid    = 1'b0;
    logic        m_adel     = 1'b0;
    logic        m_boot     = 1'b1;
    held_t       held[$];

    // A word reaches IF/ID, is parked while decode stalls, or is replaced
    // by a bubble, following the fetch rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc      <= RESET_PC;
            m_ifid_pc <= RESET_PC;
            m_instr   <= NOP_INSTR;
            m_valid   <= 1'b0;
            m_adel    <= 1'b0;
            m_boot    <= 1'b1;
            held.delete();
        end else if (flush) begin
            m_instr <= NOP_INSTR;
            m_valid <= 1'b0;
            m_adel  <= 1'b0;
            m_pc    <= nextpc;
            m_boot  <= 1'b0;
            held.delete();
        end else if (m_boot) begin
            m_boot <= 1'b0;
        end else if (held.size() != 0) begin
            if (!stall) begin
                m_ifid_pc <= m_pc;
                m_instr   <= held[0].instr;
                m_adel    <= held[0].adel;
                m_valid   <= 1'b1;
                m_pc      <= nextpc;
                held.delete();
            end
        end else if ((m_pc[1:0] != 2'b00) || imem_ready) begin
            if (stall) begin
                held.push_back('{instr: (m_pc[1:0] != 2'b00) ? NOP_INSTR : imem_rdata,
                                 adel:  (m_pc[1:0] != 2'b00)});
            end else begin
                m_ifid_pc <= m_pc;
                m_instr   <= (m_pc[1:0] != 2'b00) ? NOP_INSTR : imem_rdata;
                m_adel    <= (m_pc[1:0] != 2'b00);
                m_valid   <= 1'b1;
                m_pc      <= nextpc;
            end
        end else if (!stall) begin
            m_instr <= NOP_INSTR;
            m_valid <= 1'b0;
            m_adel  <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_imem_req",  {31'd0, imem_req},
                  {31'd0, !m_boot && (held.size() == 0) && (m_pc[1:0] == 2'b00)});
            check("m_imem_addr", imem_addr, m_pc);
            check("m_pc",        pc, m_pc);
            check("m_if_id_pc",  if_id_pc, m_ifid_pc);
            check("m_if_id_ins", if_id_instr, m_instr);
            check("m_if_id_val", {31'd0, if_id_valid}, {31'd0, m_valid});
            check("m_if_id_adl", {31'd0, if_id_adel}, {31'd0, m_adel});
        end
    end

    // ---------------- stimulus helpers ----------------
    // Drive one cycle of inputs (called at negedge+1), then return at the
    // next negedge+1 with the post-edge outputs settled.
    task automatic cyc(input logic st, input logic fl, input logic rdy,
                       input logic [31:0] rd, input logic [31:0] np);
        stall      = st;
        flush      = fl;
        imem_ready = rdy;
        imem_rdata = rd;
        nextpc     = np;
        @(negedge clk);
        #1;
    endtask

    task automatic expect_ifid(input string name, input logic [31:0] epc,
                               input logic [31:0] einstr, input logic evalid,
                               input logic eadel);
        check({name, "_pc"},    if_id_pc, epc);
        check({name, "_instr"}, if_id_instr, einstr);
        check({name, "_valid"}, {31'd0, if_id_valid}, {31'd0, evalid});
        check({name, "_adel"},  {31'd0, if_id_adel}, {31'd0, eadel});
    endtask

    task automatic expect_reset_outputs(input string name);
        check({name, "_req"}, {31'd0, imem_req}, 32'd0);
        check({name, "_pc"},  pc, RESET_PC);
        expect_ifid(name, RESET_PC, NOP_INSTR, 1'b0, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] np;
        int          sel;

        rst_n      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        nextpc     = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        cmp_en = 1'b1;
        expect_reset_outputs("rst");

        // 1: boot dead cycle, then sequential fetch 0, 4
        rst_n = 1'b1;
        check("boot_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'h1111_0000, 32'h4);
        check("fetch0_req", {31'd0, imem_req}, 32'd1);
        check("fetch0_addr", imem_addr, 32'h0);
        check("fetch0_val", {31'd0, if_id_valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'h1111_0000, 32'h4);
        expect_ifid("seq0", 32'h0, 32'h1111_0000, 1'b1, 1'b0);
        check("seq0_pcnext", pc, 32'h4);
        cyc(1'b0, 1'b0, 1'b1, 32'h1111_0004, 32'h8);
        expect_ifid("seq4", 32'h4, 32'h1111_0004, 1'b1, 1'b0);
        check("seq4_pcnext", pc, 32'h8);

        // 2: memory not ready for two cycles at pc 0x8
        cyc(1'b0, 1'b0, 1'b0, 32'hDEAD_0001, 32'hC);
        expect_ifid("bub1", 32'h4, NOP_INSTR, 1'b0, 1'b0);
        check("bub1_addr", imem_addr, 32'h8);
        cyc(1'b0, 1'b0, 1'b0, 32'hDEAD_0002, 32'hC);
        expect_ifid("bub2", 32'h4, NOP_INSTR, 1'b0, 1'b0);
        check("bub2_addr", imem_addr, 32'h8);
        cyc(1'b0, 1'b0, 1'b1, 32'h1111_0008, 32'hC);
        expect_ifid("seq8", 32'h8, 32'h1111_0008, 1'b1, 1'b0);

        // 3: three stall cycles around a ready return at pc 0xC
        cyc(1'b1, 1'b0, 1'b1, 32'h1111_000C, 32'h10);
        check("hold1_req", {31'd0, imem_req}, 32'd0);
        expect_ifid("hold1", 32'h8, 32'h1111_0008, 1'b1, 1'b0);
        check("hold1_pc", pc, 32'hC);
        cyc(1'b1, 1'b0, 1'b1, 32'hDEAD_0003, 32'h10);
        cyc(1'b1, 1'b0, 1'b1, 32'hDEAD_0004, 32'h10);
        expect_ifid("hold3", 32'h8, 32'h1111_0008, 1'b1, 1'b0);
        check("hold3_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'hDEAD_0005, 32'h10);
        expect_ifid("unhold", 32'hC, 32'h1111_000C, 1'b1, 1'b0);
        check("unhold_pc", pc, 32'h10);

        // 4: flush while holding, redirect to 0x0
        cyc(1'b1, 1'b0, 1'b1, 32'h1111_0010, 32'h14);
        check("hold4_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 32'hDEAD_0006, 32'h0);
        expect_ifid("flush", 32'hC, NOP_INSTR, 1'b0, 1'b0);
        check("flush_pc", pc, 32'h0);
        check("flush_req", {31'd0, imem_req}, 32'd1);

        // 5: misaligned redirect to 0x6
        cyc(1'b0, 1'b0, 1'b1, 32'h2222_0000, 32'h6);
        expect_ifid("pre_mis", 32'h0, 32'h2222_0000, 1'b1, 1'b0);
        check("mis_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'hDEAD_0007, 32'hA);
        expect_ifid("adel6", 32'h6, NOP_INSTR, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 32'hDEAD_0008, 32'h10);
        expect_ifid("adelA", 32'hA, NOP_INSTR, 1'b1, 1'b1);
        check("adelA_pc", pc, 32'h10);

        // 6: asynchronous reset mid-HOLD, between clock edges
        cyc(1'b1, 1'b0, 1'b1, 32'h3333_0010, 32'h14);
        check("hold6_req", {31'd0, imem_req}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset_outputs("arst");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        stall = 1'b0;
        check("reboot_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'h4444_0000, 32'h4);
        check("reboot_fetch", {31'd0, imem_req}, 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 32'h4444_0000, 32'h4);
        expect_ifid("reboot0", 32'h0, 32'h4444_0000, 1'b1, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 70)      np = m_pc + 32'd4;
            else if (sel < 85) np = {$urandom_range(0, 255), 2'b00};
            else if (sel < 95) np = (m_pc + 32'd4) | {30'd0, 2'($urandom_range(1, 3))};
            else               np = 32'd0;
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 11) == 0,
                $urandom_range(0, 9) < 7,
                $urandom,
                np);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                expect_reset_outputs("rnd_arst");
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        cmp_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
